dispatcher: RTL and testbench

- Issue stage of the Tomasulo core; transmitting end of the dispatcher→RS interface.
- Takes one decoded instruction per cycle from the instruction queue and allocates the ROB tail entry.
- Renames source registers through an internal register status table (RST) and drives one fully-resolved entry to the RS and the ROB.
- Resolves operands from the register file, ROB ready values and same-cycle CDB broadcasts.

---
 rtl/dispatcher_pkg.sv | 67 ++++++
 rtl/dispatcher_reg_status_table.sv | 49 ++++
 rtl/dispatcher.sv | 186 ++++++++++++++++++
 tb/tb_dispatcher.sv | 316 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/dispatcher_pkg.sv
// Shared widths, opcode encoding and opcode-class helpers for the issue stage.
package dispatcher_pkg;

    localparam int unsigned IDWidth       = 32;
    localparam int unsigned AddressWidth  = 32;
    localparam int unsigned ROBWidth      = 4;
    localparam int unsigned InstTypeWidth = 6;
    localparam int unsigned RegCount      = 32;
    localparam int unsigned RegIdxWidth   = 5;

    typedef enum logic [InstTypeWidth-1:0] {
        OP_NOP   = 6'd0,
        OP_LUI   = 6'd1,  OP_AUIPC = 6'd2,  OP_JAL   = 6'd3,  OP_JALR  = 6'd4,
        OP_ADDI  = 6'd5,  OP_SLTI  = 6'd6,  OP_SLTIU = 6'd7,  OP_XORI  = 6'd8,
        OP_ORI   = 6'd9,  OP_ANDI  = 6'd10, OP_SLLI  = 6'd11, OP_SRLI  = 6'd12,
        OP_SRAI  = 6'd13,
        OP_ADD   = 6'd14, OP_SUB   = 6'd15, OP_SLL   = 6'd16, OP_SLT   = 6'd17,
        OP_SLTU  = 6'd18, OP_XOR   = 6'd19, OP_OR    = 6'd20, OP_AND   = 6'd21,
        OP_SRL   = 6'd22, OP_SRA   = 6'd23,
        OP_LB    = 6'd24, OP_LH    = 6'd25, OP_LW    = 6'd26, OP_LBU   = 6'd27,
        OP_LHU   = 6'd28,
        OP_SB    = 6'd29, OP_SH    = 6'd30, OP_SW    = 6'd31,
        OP_BEQ   = 6'd32, OP_BNE   = 6'd33, OP_BLT   = 6'd34, OP_BGE   = 6'd35,
        OP_BLTU  = 6'd36, OP_BGEU  = 6'd37
    } opcode_e;

    typedef struct packed {
        logic [ROBWidth-1:0] q;
        logic [IDWidth-1:0]  v;
    } operand_t;

    // Registered payload shared by the RS and ROB issue ports.
    typedef struct packed {
        opcode_e                 opcode;
        logic [RegIdxWidth-1:0]  rd;
        logic [IDWidth-1:0]      a;
        operand_t                j;
        operand_t                k;
        logic [ROBWidth-1:0]     dest;
        logic [AddressWidth-1:0] pc;
    } issue_t;

    function automatic logic is_load(input opcode_e op);
        return op inside {[OP_LB:OP_LHU]};
    endfunction

    function automatic logic is_store(input opcode_e op);
        return op inside {[OP_SB:OP_SW]};
    endfunction

    function automatic logic is_branch(input opcode_e op);
        return op inside {[OP_BEQ:OP_BGEU]};
    endfunction

    function automatic logic writes_rd(input opcode_e op);
        return (op inside {[OP_LUI:OP_SRA]}) || is_load(op);
    endfunction

    function automatic logic uses_rs1(input opcode_e op);
        return (op inside {[OP_JALR:OP_SRA]}) || is_load(op) || is_store(op) || is_branch(op);
    endfunction

    function automatic logic uses_rs2(input opcode_e op);
        return (op inside {[OP_ADD:OP_SRA]}) || is_store(op) || is_branch(op);
    endfunction

endpackage

// File: rtl/dispatcher_reg_status_table.sv
// Register status table: per architectural register, the ROB tag of its pending producer (0 = none).
module dispatcher_reg_status_table
    import dispatcher_pkg::*;
(
    input  logic                   clk_i,
    input  logic                   rst_ni,
    input  logic                   flush_i,
    input  logic [RegIdxWidth-1:0] rd_idx1_i,
    input  logic [RegIdxWidth-1:0] rd_idx2_i,
    output logic [ROBWidth-1:0]    rd_tag1_o,
    output logic [ROBWidth-1:0]    rd_tag2_o,
    input  logic                   wr_en_i,
    input  logic [RegIdxWidth-1:0] wr_idx_i,
    input  logic [ROBWidth-1:0]    wr_tag_i,
    input  logic                   clr_en_i,
    input  logic [RegIdxWidth-1:0] clr_idx_i,
    input  logic [ROBWidth-1:0]    clr_tag_i
);

    logic [ROBWidth-1:0] tag_q [RegCount];
    logic [ROBWidth-1:0] tag_d [RegCount];

    assign rd_tag1_o = tag_q[rd_idx1_i];
    assign rd_tag2_o = tag_q[rd_idx2_i];

    // Commit clear only drops a matching tag; a dispatch write is applied last so it wins.
    always_comb begin
        tag_d = tag_q;
        if (flush_i) begin
            tag_d = '{default: '0};
        end else begin
            if (clr_en_i && (tag_q[clr_idx_i] == clr_tag_i)) begin
                tag_d[clr_idx_i] = '0;
            end
            if (wr_en_i) begin
                tag_d[wr_idx_i] = wr_tag_i;
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            tag_q <= '{default: '0};
        end else begin
            tag_q <= tag_d;
        end
    end

endmodule

// File: rtl/dispatcher.sv
// Tomasulo issue stage: renames sources through the RST, resolves operands and issues to RS/ROB.
module dispatcher
    import dispatcher_pkg::*;
(
    input  logic                     clk_in,
    input  logic                     rst_n_in,
    input  logic                     rdy_in,

    input  logic                     instqueue_valid_in,
    input  logic [InstTypeWidth-1:0] instqueue_opcode_in,
    input  logic [4:0]               instqueue_rd_in,
    input  logic [4:0]               instqueue_rs1_in,
    input  logic [4:0]               instqueue_rs2_in,
    input  logic [IDWidth-1:0]       instqueue_imm_in,
    input  logic [AddressWidth-1:0]  instqueue_pc_in,
    output logic                     dispatcher_instqueue_ack_out,

    input  logic                     rs_instqueue_rdy_in,
    input  logic                     rob_dispatcher_rdy_in,
    input  logic [ROBWidth-1:0]      rob_dispatcher_tail_in,

    output logic [4:0]               dispatcher_regfile_r1_out,
    output logic [4:0]               dispatcher_regfile_r2_out,
    input  logic [IDWidth-1:0]       regfile_dispatcher_v1_in,
    input  logic [IDWidth-1:0]       regfile_dispatcher_v2_in,

    output logic [ROBWidth-1:0]      dispatcher_rob_q1_out,
    output logic [ROBWidth-1:0]      dispatcher_rob_q2_out,
    input  logic                     rob_dispatcher_rdy1_in,
    input  logic                     rob_dispatcher_rdy2_in,
    input  logic [IDWidth-1:0]       rob_dispatcher_v1_in,
    input  logic [IDWidth-1:0]       rob_dispatcher_v2_in,

    input  logic                     rob_commit_en_in,
    input  logic [4:0]               rob_commit_rd_in,
    input  logic [ROBWidth-1:0]      rob_commit_tag_in,
    input  logic                     rob_rst_in,

    input  logic [ROBWidth-1:0]      cdb_alu_b_in,
    input  logic [IDWidth-1:0]       cdb_alu_result_in,
    input  logic [ROBWidth-1:0]      cdb_lbuffer_b_in,
    input  logic [IDWidth-1:0]       cdb_lbuffer_result_in,

    output logic                     dispatcher_rs_en_out,
    output logic [IDWidth-1:0]       dispatcher_rs_a_out,
    output logic [ROBWidth-1:0]      dispatcher_rs_qj_out,
    output logic [IDWidth-1:0]       dispatcher_rs_vj_out,
    output logic [ROBWidth-1:0]      dispatcher_rs_qk_out,
    output logic [IDWidth-1:0]       dispatcher_rs_vk_out,
    output logic [ROBWidth-1:0]      dispatcher_rs_dest_out,
    output logic [AddressWidth-1:0]  dispatcher_rs_pc_out,
    output logic [InstTypeWidth-1:0] dispatcher_rs_opcode_out,

    output logic                     dispatcher_rob_en_out,
    output logic [4:0]               dispatcher_rob_rd_out,
    output logic [InstTypeWidth-1:0] dispatcher_rob_opcode_out,
    output logic [AddressWidth-1:0]  dispatcher_rob_pc_out
);

    logic                accept_c;
    opcode_e             op_c;
    logic [ROBWidth-1:0] tag1_c;
    logic [ROBWidth-1:0] tag2_c;
    logic                rst_wr_en_c;
    operand_t            opj_c;
    operand_t            opk_c;

    logic   en_q;
    logic   en_d;
    issue_t issue_q;
    issue_t issue_d;

    // Operand source priority: unused/x0, no producer, ALU CDB, load CDB, ROB ready, else wait on tag.
    function automatic operand_t resolve(
        input logic                   used,
        input logic [RegIdxWidth-1:0] idx,
        input logic [ROBWidth-1:0]    tag,
        input logic [IDWidth-1:0]     rf_v,
        input logic                   rob_rdy,
        input logic [IDWidth-1:0]     rob_v,
        input logic [ROBWidth-1:0]    alu_b,
        input logic [IDWidth-1:0]     alu_v,
        input logic [ROBWidth-1:0]    lb_b,
        input logic [IDWidth-1:0]     lb_v
    );
        operand_t r;
        r = '0;
        if (!used || (idx == '0)) begin
            r = '0;
        end else if (tag == '0) begin
            r.v = rf_v;
        end else if (tag == alu_b) begin
            r.v = alu_v;
        end else if (tag == lb_b) begin
            r.v = lb_v;
        end else if (rob_rdy) begin
            r.v = rob_v;
        end else begin
            r.q = tag;
        end
        return r;
    endfunction

    assign accept_c = rdy_in & ~rob_rst_in & instqueue_valid_in
                    & rs_instqueue_rdy_in & rob_dispatcher_rdy_in;
    assign op_c     = opcode_e'(instqueue_opcode_in);

    assign dispatcher_instqueue_ack_out = accept_c;
    assign dispatcher_regfile_r1_out    = instqueue_rs1_in;
    assign dispatcher_regfile_r2_out    = instqueue_rs2_in;
    assign dispatcher_rob_q1_out        = tag1_c;
    assign dispatcher_rob_q2_out        = tag2_c;

    assign rst_wr_en_c = accept_c & writes_rd(op_c) & (instqueue_rd_in != '0);

    dispatcher_reg_status_table u_rst (
        .clk_i     (clk_in),
        .rst_ni    (rst_n_in),
        .flush_i   (rob_rst_in),
        .rd_idx1_i (instqueue_rs1_in),
        .rd_idx2_i (instqueue_rs2_in),
        .rd_tag1_o (tag1_c),
        .rd_tag2_o (tag2_c),
        .wr_en_i   (rst_wr_en_c),
        .wr_idx_i  (instqueue_rd_in),
        .wr_tag_i  (rob_dispatcher_tail_in),
        .clr_en_i  (rdy_in & rob_commit_en_in),
        .clr_idx_i (rob_commit_rd_in),
        .clr_tag_i (rob_commit_tag_in)
    );

    always_comb begin
        opj_c = resolve(uses_rs1(op_c), instqueue_rs1_in, tag1_c, regfile_dispatcher_v1_in,
                        rob_dispatcher_rdy1_in, rob_dispatcher_v1_in,
                        cdb_alu_b_in, cdb_alu_result_in, cdb_lbuffer_b_in, cdb_lbuffer_result_in);
        opk_c = resolve(uses_rs2(op_c), instqueue_rs2_in, tag2_c, regfile_dispatcher_v2_in,
                        rob_dispatcher_rdy2_in, rob_dispatcher_v2_in,
                        cdb_alu_b_in, cdb_alu_result_in, cdb_lbuffer_b_in, cdb_lbuffer_result_in);
    end

    // Flush kills the strobe; a global stall freezes strobe and payload.
    always_comb begin
        en_d    = en_q;
        issue_d = issue_q;
        if (rob_rst_in) begin
            en_d = 1'b0;
        end else if (rdy_in) begin
            en_d = accept_c;
            if (accept_c) begin
                issue_d.opcode = op_c;
                issue_d.rd     = writes_rd(op_c) ? instqueue_rd_in : 5'd0;
                issue_d.a      = instqueue_imm_in;
                issue_d.j      = opj_c;
                issue_d.k      = opk_c;
                issue_d.dest   = rob_dispatcher_tail_in;
                issue_d.pc     = instqueue_pc_in;
            end
        end
    end

    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            en_q    <= 1'b0;
            issue_q <= '0;
        end else begin
            en_q    <= en_d;
            issue_q <= issue_d;
        end
    end

    assign dispatcher_rs_en_out      = en_q;
    assign dispatcher_rs_a_out       = issue_q.a;
    assign dispatcher_rs_qj_out      = issue_q.j.q;
    assign dispatcher_rs_vj_out      = issue_q.j.v;
    assign dispatcher_rs_qk_out      = issue_q.k.q;
    assign dispatcher_rs_vk_out      = issue_q.k.v;
    assign dispatcher_rs_dest_out    = issue_q.dest;
    assign dispatcher_rs_pc_out      = issue_q.pc;
    assign dispatcher_rs_opcode_out  = issue_q.opcode;

    assign dispatcher_rob_en_out     = en_q;
    assign dispatcher_rob_rd_out     = issue_q.rd;
    assign dispatcher_rob_opcode_out = issue_q.opcode;
    assign dispatcher_rob_pc_out     = issue_q.pc;

endmodule

// File: tb/tb_dispatcher.sv
// Directed + randomized bench for the dispatcher, checked against a register-status reference model.
module tb_dispatcher;
    import dispatcher_pkg::*;

    logic        clk_in = 1'b0;
    logic        rst_n_in, rdy_in;
    logic        instqueue_valid_in;
    logic [5:0]  instqueue_opcode_in;
    logic [4:0]  instqueue_rd_in, instqueue_rs1_in, instqueue_rs2_in;
    logic [31:0] instqueue_imm_in, instqueue_pc_in;
    logic        dispatcher_instqueue_ack_out;
    logic        rs_instqueue_rdy_in, rob_dispatcher_rdy_in;
    logic [3:0]  rob_dispatcher_tail_in;
    logic [4:0]  dispatcher_regfile_r1_out, dispatcher_regfile_r2_out;
    logic [31:0] regfile_dispatcher_v1_in, regfile_dispatcher_v2_in;
    logic [3:0]  dispatcher_rob_q1_out, dispatcher_rob_q2_out;
    logic        rob_dispatcher_rdy1_in, rob_dispatcher_rdy2_in;
    logic [31:0] rob_dispatcher_v1_in, rob_dispatcher_v2_in;
    logic        rob_commit_en_in;
    logic [4:0]  rob_commit_rd_in;
    logic [3:0]  rob_commit_tag_in;
    logic        rob_rst_in;
    logic [3:0]  cdb_alu_b_in, cdb_lbuffer_b_in;
    logic [31:0] cdb_alu_result_in, cdb_lbuffer_result_in;
    logic        dispatcher_rs_en_out;
    logic [31:0] dispatcher_rs_a_out, dispatcher_rs_vj_out, dispatcher_rs_vk_out, dispatcher_rs_pc_out;
    logic [3:0]  dispatcher_rs_qj_out, dispatcher_rs_qk_out, dispatcher_rs_dest_out;
    logic [5:0]  dispatcher_rs_opcode_out, dispatcher_rob_opcode_out;
    logic        dispatcher_rob_en_out;
    logic [4:0]  dispatcher_rob_rd_out;
    logic [31:0] dispatcher_rob_pc_out;

    dispatcher dut (
        .clk_in(clk_in), .rst_n_in(rst_n_in), .rdy_in(rdy_in),
        .instqueue_valid_in(instqueue_valid_in), .instqueue_opcode_in(instqueue_opcode_in),
        .instqueue_rd_in(instqueue_rd_in), .instqueue_rs1_in(instqueue_rs1_in),
        .instqueue_rs2_in(instqueue_rs2_in), .instqueue_imm_in(instqueue_imm_in),
        .instqueue_pc_in(instqueue_pc_in), .dispatcher_instqueue_ack_out(dispatcher_instqueue_ack_out),
        .rs_instqueue_rdy_in(rs_instqueue_rdy_in), .rob_dispatcher_rdy_in(rob_dispatcher_rdy_in),
        .rob_dispatcher_tail_in(rob_dispatcher_tail_in),
        .dispatcher_regfile_r1_out(dispatcher_regfile_r1_out), .dispatcher_regfile_r2_out(dispatcher_regfile_r2_out),
        .regfile_dispatcher_v1_in(regfile_dispatcher_v1_in), .regfile_dispatcher_v2_in(regfile_dispatcher_v2_in),
        .dispatcher_rob_q1_out(dispatcher_rob_q1_out), .dispatcher_rob_q2_out(dispatcher_rob_q2_out),
        .rob_dispatcher_rdy1_in(rob_dispatcher_rdy1_in), .rob_dispatcher_rdy2_in(rob_dispatcher_rdy2_in),
        .rob_dispatcher_v1_in(rob_dispatcher_v1_in), .rob_dispatcher_v2_in(rob_dispatcher_v2_in),
        .rob_commit_en_in(rob_commit_en_in), .rob_commit_rd_in(rob_commit_rd_in),
        .rob_commit_tag_in(rob_commit_tag_in), .rob_rst_in(rob_rst_in),
        .cdb_alu_b_in(cdb_alu_b_in), .cdb_alu_result_in(cdb_alu_result_in),
        .cdb_lbuffer_b_in(cdb_lbuffer_b_in), .cdb_lbuffer_result_in(cdb_lbuffer_result_in),
        .dispatcher_rs_en_out(dispatcher_rs_en_out), .dispatcher_rs_a_out(dispatcher_rs_a_out),
        .dispatcher_rs_qj_out(dispatcher_rs_qj_out), .dispatcher_rs_vj_out(dispatcher_rs_vj_out),
        .dispatcher_rs_qk_out(dispatcher_rs_qk_out), .dispatcher_rs_vk_out(dispatcher_rs_vk_out),
        .dispatcher_rs_dest_out(dispatcher_rs_dest_out), .dispatcher_rs_pc_out(dispatcher_rs_pc_out),
        .dispatcher_rs_opcode_out(dispatcher_rs_opcode_out),
        .dispatcher_rob_en_out(dispatcher_rob_en_out), .dispatcher_rob_rd_out(dispatcher_rob_rd_out),
        .dispatcher_rob_opcode_out(dispatcher_rob_opcode_out), .dispatcher_rob_pc_out(dispatcher_rob_pc_out)
    );

    always #5 clk_in = ~clk_in;

    int errors = 0;
    int checks = 0;

    // Reference state: pending producer tag per register, and the last issued payload.
    int          m_tag [32];
    logic        e_en;
    logic [31:0] e_a, e_vj, e_vk, e_pc;
    logic [3:0]  e_qj, e_qk, e_dest;
    logic [5:0]  e_op;
    logic [4:0]  e_rd;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Opcode classes stated directly from the ISA grouping.
    function automatic bit m_uses1(input int op);
        return !(op == int'(OP_NOP) || op == int'(OP_LUI) || op == int'(OP_AUIPC) || op == int'(OP_JAL));
    endfunction
    function automatic bit m_uses2(input int op);
        return (op >= int'(OP_ADD) && op <= int'(OP_SRA)) || op >= int'(OP_SB);
    endfunction
    function automatic bit m_writes(input int op);
        return op != int'(OP_NOP) && op < int'(OP_SB);
    endfunction

    task automatic m_resolve(input bit used, input int idx, input logic [31:0] rfv, input bit rrdy,
                             input logic [31:0] rv, output logic [3:0] q, output logic [31:0] v);
        int t;
        t = m_tag[idx];
        q = 4'd0;
        v = 32'd0;
        if (!used || idx == 0) v = 32'd0;
        else if (t == 0) v = rfv;
        else if (t == int'(cdb_alu_b_in)) v = cdb_alu_result_in;
        else if (t == int'(cdb_lbuffer_b_in)) v = cdb_lbuffer_result_in;
        else if (rrdy) v = rv;
        else q = 4'(t);
    endtask

    task automatic set_idle();
        rdy_in = 1; instqueue_valid_in = 0; instqueue_opcode_in = 6'd0;
        instqueue_rd_in = 0; instqueue_rs1_in = 0; instqueue_rs2_in = 0;
        instqueue_imm_in = 0; instqueue_pc_in = 0;
        rs_instqueue_rdy_in = 1; rob_dispatcher_rdy_in = 1; rob_dispatcher_tail_in = 4'd1;
        regfile_dispatcher_v1_in = 0; regfile_dispatcher_v2_in = 0;
        rob_dispatcher_rdy1_in = 0; rob_dispatcher_rdy2_in = 0;
        rob_dispatcher_v1_in = 0; rob_dispatcher_v2_in = 0;
        rob_commit_en_in = 0; rob_commit_rd_in = 0; rob_commit_tag_in = 0; rob_rst_in = 0;
        cdb_alu_b_in = 0; cdb_alu_result_in = 0; cdb_lbuffer_b_in = 0; cdb_lbuffer_result_in = 0;
    endtask

    task automatic model_reset();
        foreach (m_tag[i]) m_tag[i] = 0;
        e_en = 0; e_a = 0; e_vj = 0; e_vk = 0; e_pc = 0;
        e_qj = 0; e_qk = 0; e_dest = 0; e_op = 6'd0; e_rd = 0;
    endtask

    task automatic set_inst(input opcode_e op, input int rd, input int rs1, input int rs2,
                            input logic [31:0] imm, input logic [3:0] tail);
        instqueue_valid_in = 1; instqueue_opcode_in = op;
        instqueue_rd_in = 5'(rd); instqueue_rs1_in = 5'(rs1); instqueue_rs2_in = 5'(rs2);
        instqueue_imm_in = imm; instqueue_pc_in = 32'h1000 + 32'(rd * 4);
        rob_dispatcher_tail_in = tail;
    endtask

    // One clock: check combinational outputs, predict, clock, check registered outputs.
    task automatic tick();
        bit          acc;
        int          op;
        logic [3:0]  qj, qk;
        logic [31:0] vj, vk;
        #1;
        op  = int'(instqueue_opcode_in);
        acc = rdy_in && !rob_rst_in && instqueue_valid_in && rs_instqueue_rdy_in && rob_dispatcher_rdy_in;
        chk("ack", 32'(dispatcher_instqueue_ack_out), 32'(acc));
        chk("r1", 32'(dispatcher_regfile_r1_out), 32'(instqueue_rs1_in));
        chk("r2", 32'(dispatcher_regfile_r2_out), 32'(instqueue_rs2_in));
        chk("q1_probe", 32'(dispatcher_rob_q1_out), 32'(m_tag[instqueue_rs1_in]));
        chk("q2_probe", 32'(dispatcher_rob_q2_out), 32'(m_tag[instqueue_rs2_in]));
        m_resolve(m_uses1(op), int'(instqueue_rs1_in), regfile_dispatcher_v1_in,
                  rob_dispatcher_rdy1_in, rob_dispatcher_v1_in, qj, vj);
        m_resolve(m_uses2(op), int'(instqueue_rs2_in), regfile_dispatcher_v2_in,
                  rob_dispatcher_rdy2_in, rob_dispatcher_v2_in, qk, vk);
        @(posedge clk_in);
        #1;
        if (rob_rst_in) begin
            foreach (m_tag[i]) m_tag[i] = 0;
            e_en = 0;
        end else if (rdy_in) begin
            e_en = acc;
            if (rob_commit_en_in && m_tag[rob_commit_rd_in] == int'(rob_commit_tag_in))
                m_tag[rob_commit_rd_in] = 0;
            if (acc) begin
                e_a = instqueue_imm_in; e_pc = instqueue_pc_in; e_op = 6'(op);
                e_qj = qj; e_vj = vj; e_qk = qk; e_vk = vk; e_dest = rob_dispatcher_tail_in;
                e_rd = m_writes(op) ? instqueue_rd_in : 5'd0;
                if (m_writes(op) && instqueue_rd_in != 0) m_tag[instqueue_rd_in] = int'(rob_dispatcher_tail_in);
            end
        end
        chk("rs_en", 32'(dispatcher_rs_en_out), 32'(e_en));
        chk("rob_en", 32'(dispatcher_rob_en_out), 32'(e_en));
        if (e_en) begin
            chk("a", dispatcher_rs_a_out, e_a);
            chk("qj", 32'(dispatcher_rs_qj_out), 32'(e_qj));
            chk("vj", dispatcher_rs_vj_out, e_vj);
            chk("qk", 32'(dispatcher_rs_qk_out), 32'(e_qk));
            chk("vk", dispatcher_rs_vk_out, e_vk);
            chk("dest", 32'(dispatcher_rs_dest_out), 32'(e_dest));
            chk("rs_pc", dispatcher_rs_pc_out, e_pc);
            chk("rob_pc", dispatcher_rob_pc_out, e_pc);
            chk("rs_op", 32'(dispatcher_rs_opcode_out), 32'(e_op));
            chk("rob_op", 32'(dispatcher_rob_opcode_out), 32'(e_op));
            chk("rob_rd", 32'(dispatcher_rob_rd_out), 32'(e_rd));
        end
    endtask

    initial begin
        set_idle();
        model_reset();
        rst_n_in = 0;
        repeat (2) @(posedge clk_in);
        #3;
        chk("rst_en", 32'(dispatcher_rs_en_out), 32'd0);
        chk("rst_rob_en", 32'(dispatcher_rob_en_out), 32'd0);
        chk("rst_op", 32'(dispatcher_rs_opcode_out), 32'(OP_NOP));
        chk("rst_rob_op", 32'(dispatcher_rob_opcode_out), 32'(OP_NOP));
        chk("rst_a", dispatcher_rs_a_out, 32'd0);
        chk("rst_dest", 32'(dispatcher_rs_dest_out), 32'd0);
        chk("rst_rob_rd", 32'(dispatcher_rob_rd_out), 32'd0);
        rst_n_in = 1;
        @(posedge clk_in); #1;

        // ADDI x1,x0,5 with tail 3
        set_inst(OP_ADDI, 1, 0, 0, 32'd5, 4'd3);
        regfile_dispatcher_v1_in = 32'hdead;
        tick();
        chk("addi_en", 32'(dispatcher_rs_en_out), 32'd1);
        chk("addi_qj", 32'(dispatcher_rs_qj_out), 32'd0);
        chk("addi_vj", dispatcher_rs_vj_out, 32'd0);
        chk("addi_a", dispatcher_rs_a_out, 32'd5);
        chk("addi_dest", 32'(dispatcher_rs_dest_out), 32'd3);

        // ADD x2,x1,x1 while tag 3 still pending
        set_inst(OP_ADD, 2, 1, 1, 32'd0, 4'd4);
        tick();
        chk("add_qj", 32'(dispatcher_rs_qj_out), 32'd3);
        chk("add_qk", 32'(dispatcher_rs_qk_out), 32'd3);
        chk("add_dest", 32'(dispatcher_rs_dest_out), 32'd4);

        // Same ADD with tag 3 on the ALU CDB
        set_inst(OP_ADD, 2, 1, 1, 32'd0, 4'd5);
        cdb_alu_b_in = 4'd3; cdb_alu_result_in = 32'd5;
        tick();
        chk("cdb_qj", 32'(dispatcher_rs_qj_out), 32'd0);
        chk("cdb_vj", dispatcher_rs_vj_out, 32'd5);
        chk("cdb_vk", dispatcher_rs_vk_out, 32'd5);
        cdb_alu_b_in = 0; cdb_alu_result_in = 0;

        // RS full stalls issue
        set_inst(OP_ADDI, 3, 0, 0, 32'd9, 4'd6);
        rs_instqueue_rdy_in = 0;
        repeat (3) begin
            tick();
            chk("stall_en", 32'(dispatcher_rs_en_out), 32'd0);
        end
        rs_instqueue_rdy_in = 1;
        tick();
        chk("unstall_en", 32'(dispatcher_rs_en_out), 32'd1);

        // Commit of x1/tag3 coincident with new dispatch to x1
        set_inst(OP_ADDI, 1, 0, 0, 32'd1, 4'd7);
        rob_commit_en_in = 1; rob_commit_rd_in = 5'd1; rob_commit_tag_in = 4'd3;
        tick();
        instqueue_valid_in = 0; instqueue_rs1_in = 5'd1;
        tick();
        chk("rst1_after_commit", 32'(dispatcher_rob_q1_out), 32'd7);
        rob_commit_en_in = 0;
        tick();
        chk("rst1_stale_commit", 32'(dispatcher_rob_q1_out), 32'd7);

        // Flush clears the RST and the strobe
        set_inst(OP_ADD, 5, 1, 2, 32'd0, 4'd8);
        rob_rst_in = 1;
        tick();
        chk("flush_en", 32'(dispatcher_rs_en_out), 32'd0);
        rob_rst_in = 0;
        set_inst(OP_ADDI, 4, 1, 0, 32'd2, 4'd9);
        regfile_dispatcher_v1_in = 32'h1234;
        tick();
        chk("flush_qj", 32'(dispatcher_rs_qj_out), 32'd0);
        chk("flush_vj", dispatcher_rs_vj_out, 32'h1234);

        // Global stall holds the strobe
        set_inst(OP_LW, 6, 4, 0, 32'd8, 4'd10);
        rdy_in = 0;
        tick();
        chk("rdy_hold_en", 32'(dispatcher_rs_en_out), 32'd1);
        rdy_in = 1;

        // Randomized traffic
        set_idle();
        for (int n = 0; n < 600; n++) begin
            instqueue_valid_in    = ($urandom_range(0, 9) != 0);
            rs_instqueue_rdy_in   = ($urandom_range(0, 9) > 1);
            rob_dispatcher_rdy_in = ($urandom_range(0, 9) != 0);
            rdy_in                = ($urandom_range(0, 9) != 0);
            rob_rst_in            = ($urandom_range(0, 49) == 0);
            instqueue_opcode_in   = 6'($urandom_range(0, 37));
            instqueue_rd_in       = 5'($urandom_range(0, 7));
            instqueue_rs1_in      = 5'($urandom_range(0, 7));
            instqueue_rs2_in      = 5'($urandom_range(0, 7));
            instqueue_imm_in      = $urandom;
            instqueue_pc_in       = $urandom;
            rob_dispatcher_tail_in = 4'($urandom_range(1, 15));
            regfile_dispatcher_v1_in = $urandom;
            regfile_dispatcher_v2_in = $urandom;
            rob_dispatcher_rdy1_in = 1'($urandom_range(0, 1));
            rob_dispatcher_rdy2_in = 1'($urandom_range(0, 1));
            rob_dispatcher_v1_in   = $urandom;
            rob_dispatcher_v2_in   = $urandom;
            cdb_alu_b_in      = ($urandom_range(0, 2) == 0) ? 4'(m_tag[instqueue_rs1_in]) : 4'($urandom_range(0, 15));
            cdb_lbuffer_b_in  = ($urandom_range(0, 2) == 0) ? 4'(m_tag[instqueue_rs2_in]) : 4'($urandom_range(0, 15));
            cdb_alu_result_in     = $urandom;
            cdb_lbuffer_result_in = $urandom;
            rob_commit_en_in  = ($urandom_range(0, 2) == 0);
            rob_commit_rd_in  = 5'($urandom_range(0, 7));
            rob_commit_tag_in = ($urandom_range(0, 1) == 0) ? 4'(m_tag[rob_commit_rd_in]) : 4'($urandom_range(0, 15));
            tick();
        end

        // Reset mid-issue drops the strobe immediately
        set_idle();
        set_inst(OP_ADDI, 2, 0, 0, 32'd3, 4'd2);
        tick();
        rst_n_in = 0;
        #1;
        chk("async_rst_en", 32'(dispatcher_rs_en_out), 32'd0);
        chk("async_rst_rob_en", 32'(dispatcher_rob_en_out), 32'd0);
        model_reset();
        set_idle();
        @(negedge clk_in);
        rst_n_in = 1;
        instqueue_rs1_in = 5'd2;
        #1;
        chk("async_rst_rst", 32'(dispatcher_rob_q1_out), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
